// File: rtl/rv_mem_lat_wrap_if.sv
// Pipeline-facing bundle of the memory-stage wrapper: fetch port (Q100H/Q101H)
// and data port (Q103H/Q104H), each with its own stall.
interface rv_mem_lat_wrap_if;
    logic [31:0] pc_Q100H;
    logic        fetch_en_Q100H;
    logic [31:0] instruction_Q101H;
    logic        instr_valid_Q101H;
    logic        imem_stall;

    logic [31:0] dmem_addr_Q103H;
    logic        dmem_req_Q103H;
    logic        dmem_wr_en_Q103H;
    logic [31:0] dmem_wr_data_Q103H;
    logic [3:0]  dmem_byte_en_Q103H;
    logic        dmem_is_signed_Q103H;
    logic [31:0] dmem_rd_data_Q104H;
    logic        dmem_valid_Q104H;
    logic        dmem_err_Q104H;
    logic        dmem_stall;

    modport master (
        output pc_Q100H, fetch_en_Q100H,
        output dmem_addr_Q103H, dmem_req_Q103H, dmem_wr_en_Q103H,
        output dmem_wr_data_Q103H, dmem_byte_en_Q103H, dmem_is_signed_Q103H,
        input  instruction_Q101H, instr_valid_Q101H, imem_stall,
        input  dmem_rd_data_Q104H, dmem_valid_Q104H, dmem_err_Q104H, dmem_stall
    );

    modport slave (
        input  pc_Q100H, fetch_en_Q100H,
        input  dmem_addr_Q103H, dmem_req_Q103H, dmem_wr_en_Q103H,
        input  dmem_wr_data_Q103H, dmem_byte_en_Q103H, dmem_is_signed_Q103H,
        output instruction_Q101H, instr_valid_Q101H, imem_stall,
        output dmem_rd_data_Q104H, dmem_valid_Q104H, dmem_err_Q104H, dmem_stall
    );
endinterface

// File: rtl/rv_mem_lat_wrap.sv
// Memory-stage wrapper: instruction ROM and byte-addressable data RAM, each
// behind an IDLE/BUSY wait-state port with valid pulse, stall and misalign check.
module rv_mem_lat_wrap #(
    parameter int unsigned IMEM_SIZE_WORDS = 256,
    parameter int unsigned DMEM_SIZE_BYTES = 1024,
    parameter int unsigned IMEM_WAIT       = 0,
    parameter int unsigned DMEM_WAIT       = 0,
    parameter logic [IMEM_SIZE_WORDS*32-1:0] IMEM_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    rv_mem_lat_wrap_if.slave mem_if
);
    localparam int unsigned IAW        = $clog2(IMEM_SIZE_WORDS);
    localparam int unsigned DMEM_WORDS = DMEM_SIZE_BYTES / 4;
    localparam int unsigned DAW        = $clog2(DMEM_WORDS);
    localparam logic [2:0]  IW         = 3'(IMEM_WAIT);
    localparam logic [2:0]  DW         = 3'(DMEM_WAIT);

    typedef enum logic {IDLE, BUSY} state_e;

    typedef struct packed {
        logic [DAW+1:0] addr;
        logic [31:0]    wdata;
        logic [3:0]     be;
        logic           wr;
        logic           sgn;
    } dreq_t;

    // ---------------- instruction port ----------------
    state_e         i_state_q, i_state_d;
    logic [2:0]     i_cnt_q, i_cnt_d;
    logic [IAW-1:0] i_addr_q, i_addr_d, i_issue_addr;
    logic           i_accept, i_issue, i_vld_q;
    logic [31:0]    i_instr_q;

    always_comb begin
        i_state_d    = i_state_q;
        i_cnt_d      = i_cnt_q;
        i_addr_d     = i_addr_q;
        i_issue      = 1'b0;
        i_issue_addr = i_addr_q;
        i_accept     = (i_state_q == IDLE) && mem_if.fetch_en_Q100H;
        if (i_accept) i_addr_d = mem_if.pc_Q100H[IAW+1:2];
        if (IMEM_WAIT == 0) begin
            i_issue      = i_accept;
            i_issue_addr = mem_if.pc_Q100H[IAW+1:2];
        end else begin
            case (i_state_q)
                IDLE: if (i_accept) begin
                    i_state_d = BUSY;
                    i_cnt_d   = IW;
                end
                BUSY: begin
                    i_cnt_d = i_cnt_q - 3'd1;
                    if (i_cnt_q == 3'd1) begin
                        i_issue   = 1'b1;
                        i_state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state_q <= IDLE;
            i_cnt_q   <= '0;
            i_addr_q  <= '0;
            i_vld_q   <= 1'b0;
            i_instr_q <= '0;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
            i_addr_q  <= i_addr_d;
            i_vld_q   <= i_issue;
            if (i_issue) i_instr_q <= IMEM_INIT[{i_issue_addr, 5'd0} +: 32];
        end
    end

    assign mem_if.instruction_Q101H = i_instr_q;
    assign mem_if.instr_valid_Q101H = i_vld_q;
    assign mem_if.imem_stall        = (i_state_q == BUSY);

    // ---------------- data port ----------------
    state_e      d_state_q, d_state_d;
    logic [2:0]  d_cnt_q, d_cnt_d;
    dreq_t       d_req_q, d_req_d, d_live, d_cur;
    logic        d_accept, d_issue, d_mis, d_mem_we;
    logic [31:0] d_word, d_ld, d_rd_q;
    logic        d_vld_q, d_err_q;
    logic [31:0] dmem_q [DMEM_WORDS];

    assign d_live = '{addr:  mem_if.dmem_addr_Q103H[DAW+1:0],
                      wdata: mem_if.dmem_wr_data_Q103H,
                      be:    mem_if.dmem_byte_en_Q103H,
                      wr:    mem_if.dmem_wr_en_Q103H,
                      sgn:   mem_if.dmem_is_signed_Q103H};

    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_req_d   = d_req_q;
        d_issue   = 1'b0;
        d_cur     = d_req_q;
        d_accept  = (d_state_q == IDLE) && mem_if.dmem_req_Q103H;
        if (d_accept) d_req_d = d_live;
        if (DMEM_WAIT == 0) begin
            d_issue = d_accept;
            d_cur   = d_live;
        end else begin
            case (d_state_q)
                IDLE: if (d_accept) begin
                    d_state_d = BUSY;
                    d_cnt_d   = DW;
                end
                BUSY: begin
                    d_cnt_d = d_cnt_q - 3'd1;
                    if (d_cnt_q == 3'd1) begin
                        d_issue   = 1'b1;
                        d_state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // Lane selection follows byte_en; the pipeline places store data on its lanes.
    always_comb begin
        d_mis  = ((d_cur.be == 4'b1111) && (d_cur.addr[1:0] != 2'b00)) ||
                 (((d_cur.be == 4'b0011) || (d_cur.be == 4'b1100)) && d_cur.addr[0]);
        d_word = dmem_q[d_cur.addr[DAW+1:2]];
        case (d_cur.be)
            4'b0001: d_ld = {{24{d_cur.sgn & d_word[7]}},  d_word[7:0]};
            4'b0010: d_ld = {{24{d_cur.sgn & d_word[15]}}, d_word[15:8]};
            4'b0100: d_ld = {{24{d_cur.sgn & d_word[23]}}, d_word[23:16]};
            4'b1000: d_ld = {{24{d_cur.sgn & d_word[31]}}, d_word[31:24]};
            4'b0011: d_ld = {{16{d_cur.sgn & d_word[15]}}, d_word[15:0]};
            4'b1100: d_ld = {{16{d_cur.sgn & d_word[31]}}, d_word[31:16]};
            default: d_ld = d_word;
        endcase
    end

    // rst gate keeps a zero-wait store from landing while reset is held.
    assign d_mem_we = d_issue && d_cur.wr && !d_mis && !rst;

    always_ff @(posedge clk) begin
        if (d_mem_we) begin
            if (d_cur.be[0]) dmem_q[d_cur.addr[DAW+1:2]][7:0]   <= d_cur.wdata[7:0];
            if (d_cur.be[1]) dmem_q[d_cur.addr[DAW+1:2]][15:8]  <= d_cur.wdata[15:8];
            if (d_cur.be[2]) dmem_q[d_cur.addr[DAW+1:2]][23:16] <= d_cur.wdata[23:16];
            if (d_cur.be[3]) dmem_q[d_cur.addr[DAW+1:2]][31:24] <= d_cur.wdata[31:24];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state_q <= IDLE;
            d_cnt_q   <= '0;
            d_req_q   <= '0;
            d_vld_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_rd_q    <= '0;
        end else begin
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
            d_req_q   <= d_req_d;
            d_vld_q   <= d_issue;
            d_err_q   <= d_issue && d_mis;
            if (d_issue) begin
                if (d_mis)          d_rd_q <= '0;
                else if (!d_cur.wr) d_rd_q <= d_ld;
            end
        end
    end

    assign mem_if.dmem_rd_data_Q104H = d_rd_q;
    assign mem_if.dmem_valid_Q104H   = d_vld_q;
    assign mem_if.dmem_err_Q104H     = d_err_q;
    assign mem_if.dmem_stall         = (d_state_q == BUSY);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_if.pc_Q100H[31:IAW+2], mem_if.pc_Q100H[1:0],
                                mem_if.dmem_addr_Q103H[31:DAW+2]};
endmodule

// File: tb/tb_rv_mem_lat_wrap.sv
// Scoreboard bench: three wrapper instances with different wait settings,
// directed stimulus pushes expected responses, a negedge monitor checks them.
module tb_rv_mem_lat_wrap;
    localparam int ND = 3;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    function automatic int iwait(int g);
        return (g == 0) ? 0 : (g == 1) ? 3 : 1;
    endfunction
    function automatic int dwait(int g);
        return (g == 0) ? 0 : (g == 1) ? 2 : 5;
    endfunction
    function automatic logic [31:0] rom_word(int w);
        return (w == 4) ? 32'hDEADBEEF : {16'hA5A5, 16'(w)};
    endfunction
    function automatic logic [256*32-1:0] mk_init();
        logic [256*32-1:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) r[i*32 +: 32] = rom_word(i);
        return r;
    endfunction
    localparam logic [256*32-1:0] INIT = mk_init();

    logic        clk = 1'b0;
    logic        rst_a    [ND];
    logic [31:0] pc_a     [ND];
    logic        fen_a    [ND];
    logic [31:0] daddr_a  [ND];
    logic [31:0] dwdata_a [ND];
    logic [3:0]  dbe_a    [ND];
    logic        dreq_a   [ND];
    logic        dwr_a    [ND];
    logic        dsgn_a   [ND];
    logic [31:0] instr_a  [ND];
    logic [31:0] rd_a     [ND];
    logic        ivld_a   [ND];
    logic        istall_a [ND];
    logic        dvld_a   [ND];
    logic        derr_a   [ND];
    logic        dstall_a [ND];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q [2*ND][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        rv_mem_lat_wrap_if bus ();
        assign bus.pc_Q100H             = pc_a[g];
        assign bus.fetch_en_Q100H       = fen_a[g];
        assign bus.dmem_addr_Q103H      = daddr_a[g];
        assign bus.dmem_req_Q103H       = dreq_a[g];
        assign bus.dmem_wr_en_Q103H     = dwr_a[g];
        assign bus.dmem_wr_data_Q103H   = dwdata_a[g];
        assign bus.dmem_byte_en_Q103H   = dbe_a[g];
        assign bus.dmem_is_signed_Q103H = dsgn_a[g];
        assign instr_a[g]  = bus.instruction_Q101H;
        assign ivld_a[g]   = bus.instr_valid_Q101H;
        assign istall_a[g] = bus.imem_stall;
        assign rd_a[g]     = bus.dmem_rd_data_Q104H;
        assign dvld_a[g]   = bus.dmem_valid_Q104H;
        assign derr_a[g]   = bus.dmem_err_Q104H;
        assign dstall_a[g] = bus.dmem_stall;

        rv_mem_lat_wrap #(
            .IMEM_SIZE_WORDS(256),
            .DMEM_SIZE_BYTES(1024),
            .IMEM_WAIT(iwait(g)),
            .DMEM_WAIT(dwait(g)),
            .IMEM_INIT(INIT)
        ) dut (
            .clk   (clk),
            .rst   (rst_a[g]),
            .mem_if(bus)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic push(int i, int lat, logic [31:0] d, logic e);
        exp_t x;
        x.cyc = cyc + lat;
        x.data = d;
        x.err = e;
        q[i].push_back(x);
    endtask

    task automatic fetch(int k, logic [31:0] pc);
        pc_a[k]  = pc;
        fen_a[k] = 1'b1;
        push(2*k, iwait(k) + 1, rom_word(int'(pc[9:2])), 1'b0);
    endtask

    task automatic drv_d(int k, logic wr, logic [31:0] a, logic [31:0] wd, logic [3:0] be, logic sg);
        daddr_a[k]  = a;
        dwdata_a[k] = wd;
        dbe_a[k]    = be;
        dwr_a[k]    = wr;
        dsgn_a[k]   = sg;
        dreq_a[k]   = 1'b1;
    endtask

    task automatic dacc(int k, logic wr, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                        logic sg, logic [31:0] ed, logic ee);
        drv_d(k, wr, a, wd, be, sg);
        push(2*k+1, dwait(k) + 1, ed, ee);
    endtask

    task automatic idle(int k);
        fen_a[k]  = 1'b0;
        dreq_a[k] = 1'b0;
    endtask

    // Issue one access, then wait until its valid cycle, where the port is free again.
    task automatic dgo(int k, logic wr, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                       logic sg, logic [31:0] ed, logic ee);
        dacc(k, wr, a, wd, be, sg, ed, ee);
        tick();
        idle(k);
        repeat (dwait(k)) tick();
    endtask

    task automatic mon(int i, logic v, logic [31:0] d, logic e);
        exp_t x;
        if (q[i].size() != 0 && q[i][0].cyc < cyc) begin
            checks++;
            errors++;
            x = q[i].pop_front();
            $display("FAIL missing_valid port%0d: got none expected at cycle %0d", i, x.cyc);
        end
        if (v) begin
            checks++;
            if (q[i].size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid port%0d: got valid at cycle %0d expected none", i, cyc);
            end else begin
                x = q[i].pop_front();
                if (x.cyc != cyc || x.data !== d || x.err !== e) begin
                    errors++;
                    $display("FAIL resp port%0d: got cyc %0d data %h err %b expected cyc %0d data %h err %b",
                             i, cyc, d, e, x.cyc, x.data, x.err);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            mon(2*k,   ivld_a[k], instr_a[k], 1'b0);
            mon(2*k+1, dvld_a[k], rd_a[k],    derr_a[k]);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pcs [4];
        pcs = '{32'h10, 32'h12, 32'h14, 32'h410};
        for (int k = 0; k < ND; k++) begin
            rst_a[k] = 1'b1;
            pc_a[k] = '0; fen_a[k] = 1'b0;
            daddr_a[k] = '0; dwdata_a[k] = '0; dbe_a[k] = '0;
            dreq_a[k] = 1'b0; dwr_a[k] = 1'b0; dsgn_a[k] = 1'b0;
        end
        repeat (2) tick();
        for (int k = 0; k < ND; k++) begin
            chk ("rst_instr",  instr_a[k],  32'h0);
            chk1("rst_ivld",   ivld_a[k],   1'b0);
            chk1("rst_istall", istall_a[k], 1'b0);
            chk ("rst_rd",     rd_a[k],     32'h0);
            chk1("rst_dvld",   dvld_a[k],   1'b0);
            chk1("rst_derr",   derr_a[k],   1'b0);
            chk1("rst_dstall", dstall_a[k], 1'b0);
            rst_a[k] = 1'b0;
        end
        tick();

        // zero-wait instance: back-to-back fetches, pc[1:0] ignored, word index wraps
        for (int i = 0; i < 4; i++) begin
            fetch(0, pcs[i]);
            chk1("u0_istall", istall_a[0], 1'b0);
            tick();
        end
        idle(0);
        dgo(0, 1'b1, 32'h100, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0,        1'b0);
        dgo(0, 1'b0, 32'h100, 32'h0,        4'b1111, 1'b0, 32'hCAFEF00D, 1'b0);
        dgo(0, 1'b0, 32'h102, 32'h0,        4'b1100, 1'b1, 32'hFFFFCAFE, 1'b0);
        dgo(0, 1'b0, 32'h100, 32'h0,        4'b0001, 1'b0, 32'h0000000D, 1'b0);
        dgo(0, 1'b0, 32'h101, 32'h0,        4'b1111, 1'b0, 32'h0,        1'b1);
        dgo(0, 1'b1, 32'h500, 32'h000000AA, 4'b0001, 1'b0, 32'h0,        1'b0);
        chk1("u0_dstall", dstall_a[0], 1'b0);
        dgo(0, 1'b0, 32'h100, 32'h0,        4'b1111, 1'b0, 32'hCAFEF0AA, 1'b0);
        dgo(0, 1'b0, 32'h103, 32'h0,        4'b1000, 1'b1, 32'hFFFFFFCA, 1'b0);
        dgo(0, 1'b1, 32'h103, 32'h55550000, 4'b1100, 1'b0, 32'h0,        1'b1);
        dgo(0, 1'b0, 32'h100, 32'h0,        4'b1111, 1'b0, 32'hCAFEF0AA, 1'b0);

        // IMEM_WAIT=3: fetch held 8 cycles -> accepted at +0 and +4
        pc_a[1]  = 32'h10;
        fen_a[1] = 1'b1;
        push(2, 4, 32'hDEADBEEF, 1'b0);
        push(2, 8, 32'hDEADBEEF, 1'b0);
        for (int j = 0; j < 8; j++) begin
            chk1("u1_istall", istall_a[1], (j % 4) != 0);
            tick();
        end
        fen_a[1] = 1'b0;

        // DMEM_WAIT=2: byte store, signed/unsigned loads, misaligned store
        dgo(1, 1'b1, 32'h21, 32'h00008000, 4'b0010, 1'b0, 32'h0,        1'b0);
        dgo(1, 1'b0, 32'h21, 32'h0,        4'b0010, 1'b1, 32'hFFFFFF80, 1'b0);
        dgo(1, 1'b0, 32'h21, 32'h0,        4'b0010, 1'b0, 32'h00000080, 1'b0);
        dgo(1, 1'b1, 32'h40, 32'h0BADF00D, 4'b1111, 1'b0, 32'h00000080, 1'b0);
        dacc(1, 1'b1, 32'h42, 32'h12345678, 4'b1111, 1'b0, 32'h0, 1'b1);
        tick();
        chk1("u1_dstall_busy", dstall_a[1], 1'b1);
        daddr_a[1]  = 32'h40;
        dwdata_a[1] = 32'hFFFFFFFF;
        tick();
        idle(1);
        tick();
        chk1("u1_dstall_vcyc", dstall_a[1], 1'b0);
        dgo(1, 1'b0, 32'h40, 32'h0, 4'b1111, 1'b0, 32'h0BADF00D, 1'b0);

        // IMEM_WAIT=1 / DMEM_WAIT=5: simultaneous fetch and load
        dgo(2, 1'b1, 32'h80, 32'h11223344, 4'b1111, 1'b0, 32'h0, 1'b0);
        fetch(2, 32'h14);
        dacc(2, 1'b0, 32'h80, 32'h0, 4'b1111, 1'b0, 32'h11223344, 1'b0);
        tick();
        idle(2);
        for (int j = 1; j <= 6; j++) begin
            chk1("u2_istall", istall_a[2], j < 2);
            chk1("u2_dstall", dstall_a[2], j < 6);
            tick();
        end

        // reset two busy cycles into a store: aborted, no valid, memory untouched
        drv_d(2, 1'b1, 32'h80, 32'hDEADDEAD, 4'b1111, 1'b0);
        tick();
        idle(2);
        repeat (2) tick();
        chk1("u2_pre_rst_stall", dstall_a[2], 1'b1);
        chk ("u2_pre_rst_rd",    rd_a[2],     32'h11223344);
        chk ("u2_pre_rst_instr", instr_a[2],  32'hA5A50005);
        rst_a[2] = 1'b1;
        #1;
        chk ("u2_rst_rd",     rd_a[2],     32'h0);
        chk ("u2_rst_instr",  instr_a[2],  32'h0);
        chk1("u2_rst_dstall", dstall_a[2], 1'b0);
        chk1("u2_rst_dvld",   dvld_a[2],   1'b0);
        chk1("u2_rst_derr",   derr_a[2],   1'b0);
        tick();
        rst_a[2] = 1'b0;
        repeat (6) tick();
        dgo(2, 1'b0, 32'h80, 32'h0, 4'b1111, 1'b0, 32'h11223344, 1'b0);

        repeat (8) tick();
        for (int i = 0; i < 2*ND; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                errors++;
                $display("FAIL drain port%0d: got %0d pending expected 0", i, q[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
